data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter ADDRESS_LENGTH, default 32, meaning address and data width in bits.
REQ-002 SHALL have parameter SETS, default 16, meaning the number of one-word lines; power of two, 2..256.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have ports a, wd, input, ADDRESS_LENGTH bits: CPU byte address and store data.
REQ-006 SHALL have ports re, sw, sh, sb, input, 1 bit each: CPU load request and store word, half or byte.
REQ-007 SHALL have port rd, output, ADDRESS_LENGTH bits: aligned 32-bit word containing a.
REQ-008 SHALL have port stall, output, 1 bit: CPU must hold a, re, sw, sh and sb while high.
REQ-009 SHALL have ports mem_a, mem_wd, output, ADDRESS_LENGTH bits, and mem_sw, mem_sh, mem_sb, output, 1 bit each, all driving the data RAM.
REQ-010 SHALL have port mem_rd, input, ADDRESS_LENGTH bits: the RAM's combinational aligned-word read data.

Function
REQ-011 SHALL be direct-mapped, write-through, no-write-allocate, with one 32-bit word per line plus a valid bit and tag.
REQ-012 SHALL take index = a[2+log2(SETS)-1:2] and tag = a[ADDRESS_LENGTH-1:2+log2(SETS)].
REQ-013 SHALL use a two-state FSM, IDLE and FILL; reset state IDLE.
REQ-014 In IDLE, a read hit (re, valid, tag match) SHALL return rd = line data in the same cycle with stall = 0.
REQ-015 In IDLE, a read miss SHALL assert stall = 1 and drive mem_a = {a[ADDRESS_LENGTH-1:2],2'b0}, then at the clock edge write mem_rd into the line, set valid and tag, and enter FILL.
REQ-016 In FILL, stall SHALL be 0, rd SHALL equal the filled line, and the next state SHALL be IDLE; miss latency is exactly one extra cycle.
REQ-017 Every store SHALL pass through combinationally in the same cycle, with no stall: mem_a = a, mem_wd = wd, and mem_sw/sh/sb = sw/sh/sb.
REQ-018 When not storing, mem_sw, mem_sh and mem_sb SHALL be 0.
REQ-019 An aligned store hit SHALL update only the written byte lanes of the line: sb writes lane a[1:0]; sh writes lanes a[1:0] and a[1:0]+1 with a[1:0] in {0,2}; sw writes all four lanes with a[1:0] = 0.
REQ-020 An aligned store miss SHALL leave the cache unchanged.
REQ-021 A misaligned store (sh with a[1:0] = 3, or sw with a[1:0] != 0) SHALL clear valid for the set of a and the set of a+3, regardless of tag.
REQ-022 If re and a store are asserted together, the store SHALL win and re SHALL be ignored.
REQ-023 When re is low and no store is asserted, the cache state SHALL be unchanged and stall SHALL be 0.
REQ-024 If re is low in IDLE, rd SHALL be don't-care and mem_a SHALL be a.

Reset
REQ-025 On rst, the block SHALL immediately clear all valid bits and enter IDLE, with stall = 0 and mem_sw = mem_sh = mem_sb = 0.
REQ-026 An rst during FILL or during a miss cycle SHALL abandon the fill, leaving no line valid.

Configuration
REQ-027 With macro DATA_CACHE_STATS_EN defined, the block SHALL add outputs hit_count and miss_count, 32 bits each: each read hit increments hit_count, each IDLE read miss increments miss_count, both wrap at 2^32 and reset to 0.
REQ-028 Without DATA_CACHE_STATS_EN, these ports and counters SHALL not exist and behaviour SHALL be otherwise identical.

Verification
REQ-029 After reset, re at a=0x10000 with RAM word 0xDEADBEEF -> stall=1 for one cycle, then rd=0xDEADBEEF with stall=0 in FILL; a repeat re -> hit with stall=0.
REQ-030 With 0x10000 cached, sb wd=0x000000AA at a=0x10001 -> mem_sb=1 that cycle, and a following re gives rd=0xDEADAAEF with no stall.
REQ-031 Two addresses mapping to the same set (0x10000 and 0x10040 with SETS=16) -> alternating reads each miss and evict the other.
REQ-032 With 0x10000 and 0x10004 cached, sw at a=0x10002 -> both lines invalid, and the next reads of each miss.
REQ-033 rst asserted during the miss cycle of a read at 0x10008 -> stall=0 immediately, and a re-read misses.
REQ-034 With DATA_CACHE_STATS_EN, scenario REQ-029 -> hit_count=1 and miss_count=1.

Source files
------------

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache with
// one 32-bit word per line. A read miss stalls for one cycle while the line is
// filled from the combinational RAM read port; stores always pass straight
// through to the RAM without stalling.
// Optional hit/miss counters are added when DATA_CACHE_STATS_EN is defined.
module data_cache #(
  parameter int ADDRESS_LENGTH = 32,
  parameter int SETS           = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDRESS_LENGTH-1:0] a,
  input  logic [ADDRESS_LENGTH-1:0] wd,
  input  logic                      re,
  input  logic                      sw,
  input  logic                      sh,
  input  logic                      sb,
  output logic [ADDRESS_LENGTH-1:0] rd,
  output logic                      stall,
  output logic [ADDRESS_LENGTH-1:0] mem_a,
  output logic [ADDRESS_LENGTH-1:0] mem_wd,
  output logic                      mem_sw,
  output logic                      mem_sh,
  output logic                      mem_sb,
  input  logic [ADDRESS_LENGTH-1:0] mem_rd
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDRESS_LENGTH - 2 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                    state_q, state_d;
  logic [SETS-1:0]           valid_q, valid_d;
  logic [TAG_W-1:0]          tag_q  [SETS];
  logic [TAG_W-1:0]          tag_d  [SETS];
  logic [ADDRESS_LENGTH-1:0] data_q [SETS];
  logic [ADDRESS_LENGTH-1:0] data_d [SETS];

  logic [IDX_W-1:0]          idx, idx_p3;
  logic [TAG_W-1:0]          a_tag;
  logic [1:0]                ofs;
  logic                      store, hit, read_miss, misaligned;
  logic [3:0]                st_mask;
  logic [ADDRESS_LENGTH-1:0] st_data, st_merged;

  assign idx   = a[2+IDX_W-1:2];
  assign a_tag = a[ADDRESS_LENGTH-1:2+IDX_W];
  assign ofs   = a[1:0];
  // a+3 lands in the next set exactly when the byte offset is non-zero
  assign idx_p3    = idx + IDX_W'(ofs != 2'd0);
  assign store     = sw | sh | sb;
  assign hit       = valid_q[idx] && (tag_q[idx] == a_tag);
  assign read_miss = (state_q == IDLE) && re && !store && !hit;

  // Byte-lane decode of the store and merge into the currently indexed line
  always_comb begin
    st_mask    = 4'b0000;
    st_data    = wd << {ofs, 3'b000};
    misaligned = 1'b0;
    if (sw) begin
      st_mask    = 4'b1111;
      st_data    = wd;
      misaligned = (ofs != 2'd0);
    end else if (sh) begin
      st_mask    = 4'b0011 << ofs;
      misaligned = (ofs == 2'd3);
    end else if (sb) begin
      st_mask    = 4'b0001 << ofs;
    end
    st_merged = data_q[idx];
    for (int i = 0; i < 4; i++) begin
      if (st_mask[i]) st_merged[8*i +: 8] = st_data[8*i +: 8];
    end
  end

  // Next-state for FSM and line arrays; a store always takes priority over re
  always_comb begin
    state_d = IDLE;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (store) begin
      if (misaligned) begin
        valid_d[idx]    = 1'b0;
        valid_d[idx_p3] = 1'b0;
      end else if (hit) begin
        data_d[idx] = st_merged;
      end
    end else if (read_miss) begin
      valid_d[idx] = 1'b1;
      tag_d[idx]   = a_tag;
      data_d[idx]  = mem_rd;
      state_d      = FILL;
    end
  end

  // CPU and RAM side outputs; reset forces the bus quiet immediately
  always_comb begin
    rd     = data_q[idx];
    stall  = !rst && read_miss;
    mem_a  = (!rst && read_miss) ? {a[ADDRESS_LENGTH-1:2], 2'b00} : a;
    mem_wd = wd;
    mem_sw = !rst && sw;
    mem_sh = !rst && sh;
    mem_sb = !rst && sb;
  end

  // FSM state and valid bits, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Hits count only in IDLE; the FILL cycle completes a miss and is not a hit
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == IDLE && re && !store && hit) hit_count_d = hit_count_q + 32'd1;
    if (read_miss) miss_count_d = miss_count_q + 32'd1;
  end

  // Wrapping statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed CPU operations, a bench-owned RAM, and a
// behavioural cache model checked against the DUT on every falling edge.
module tb_data_cache;

  logic        clk, rst;
  logic [31:0] a, wd, rd, mem_a, mem_wd, mem_rd;
  logic        re, sw, sh, sb, stall, mem_sw, mem_sh, mem_sb;
`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] ram [0:255];

  data_cache #(.ADDRESS_LENGTH(32), .SETS(16)) dut (
    .clk(clk), .rst(rst), .a(a), .wd(wd), .re(re), .sw(sw), .sh(sh), .sb(sb),
    .rd(rd), .stall(stall), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_sw(mem_sw), .mem_sh(mem_sh), .mem_sb(mem_sb), .mem_rd(mem_rd)
`ifdef DATA_CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = ram[mem_a[9:2]];

  // Bench RAM: applies the write strobes the cache presents
  always @(posedge clk) begin
    if (mem_sw) ram[mem_a[9:2]] <= mem_wd;
    else if (mem_sh && mem_a[1:0] != 2'd3) ram[mem_a[9:2]][8*mem_a[1:0] +: 16] <= mem_wd[15:0];
    else if (mem_sb) ram[mem_a[9:2]][8*mem_a[1:0] +: 8] <= mem_wd[7:0];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Model: which word address each set holds, its data, and whether the
  // previous cycle was a read miss (so this cycle delivers the fill).
  bit          mv    [16];
  logic [31:0] mword [16];
  logic [31:0] mdat  [16];
  bit          mfill;

  function automatic int set_of(input logic [31:0] addr);
    return int'((addr >> 2) % 16);
  endfunction

  always @(negedge clk) begin
    int s, k;
    bit hit, mis;
    logic [31:0] tmp;
    if (rst) begin
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_strobes", {29'd0, mem_sw, mem_sh, mem_sb}, 32'd0);
      for (int i = 0; i < 16; i++) mv[i] = 0;
      mfill = 0;
    end else begin
      s   = set_of(a);
      k   = int'(a % 4);
      hit = mv[s] && (mword[s] == (a >> 2));
      if (sw || sh || sb) begin
        chk("st_stall", {31'd0, stall}, 32'd0);
        chk("st_mem_a", mem_a, a);
        chk("st_mem_wd", mem_wd, wd);
        chk("st_strobes", {29'd0, mem_sw, mem_sh, mem_sb}, {29'd0, sw, sh, sb});
        mis = sw ? (k != 0) : (sh ? (k == 3) : 1'b0);
        if (mis) begin
          mv[s] = 0;
          mv[set_of(a + 32'd3)] = 0;
        end else if (hit) begin
          tmp = mdat[s];
          if (sw) tmp = wd;
          else if (sh) tmp[8*k +: 16] = wd[15:0];
          else tmp[8*k +: 8] = wd[7:0];
          mdat[s] = tmp;
        end
        mfill = 0;
      end else if (re) begin
        if (mfill || hit) begin
          chk("rd_stall", {31'd0, stall}, 32'd0);
          chk("rd_data", rd, mdat[s]);
          mfill = 0;
        end else begin
          chk("miss_stall", {31'd0, stall}, 32'd1);
          chk("miss_mem_a", mem_a, a & 32'hFFFF_FFFC);
          chk("miss_strobes", {29'd0, mem_sw, mem_sh, mem_sb}, 32'd0);
          mv[s]    = 1;
          mword[s] = a >> 2;
          mdat[s]  = ram[a[9:2]];
          mfill    = 1;
        end
      end else begin
        chk("idle_stall", {31'd0, stall}, 32'd0);
        chk("idle_mem_a", mem_a, a);
        chk("idle_strobes", {29'd0, mem_sw, mem_sh, mem_sb}, 32'd0);
        mfill = 0;
      end
    end
  end

  // One CPU cycle: drive just after the rising edge, return just after the falling edge
  task automatic op(input bit r, input bit w, input bit h, input bit b,
                    input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    re = r; sw = w; sh = h; sb = b; a = addr; wd = data;
    @(negedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0BAD_0000 + i;
    ram[0] = 32'hDEAD_BEEF;
    rst = 1'b1; re = 0; sw = 0; sh = 0; sb = 0; a = 0; wd = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("reset_stall", {31'd0, stall}, 32'd0);

    // Miss, fill, hit
    op(1, 0, 0, 0, 32'h10000, 0);
    chk("lit_miss_stall", {31'd0, stall}, 32'd1);
    chk("lit_miss_mem_a", mem_a, 32'h10000);
    op(1, 0, 0, 0, 32'h10000, 0);
    chk("lit_fill_stall", {31'd0, stall}, 32'd0);
    chk("lit_fill_rd", rd, 32'hDEAD_BEEF);
    op(1, 0, 0, 0, 32'h10000, 0);
    chk("lit_hit_stall", {31'd0, stall}, 32'd0);
    chk("lit_hit_rd", rd, 32'hDEAD_BEEF);

    // Byte and half stores into a cached line
    op(0, 0, 0, 1, 32'h10001, 32'h0000_00AA);
    chk("lit_sb_strobe", {31'd0, mem_sb}, 32'd1);
`ifdef DATA_CACHE_STATS_EN
    chk("lit_hit_count", hit_count, 32'd1);
    chk("lit_miss_count", miss_count, 32'd1);
`endif
    op(1, 0, 0, 0, 32'h10000, 0);
    chk("lit_sb_rd", rd, 32'hDEAD_AAEF);
    chk("lit_sb_stall", {31'd0, stall}, 32'd0);
    op(0, 0, 1, 0, 32'h10002, 32'h0000_1234);
    op(1, 0, 0, 0, 32'h10000, 0);
    chk("lit_sh_rd", rd, 32'h1234_AAEF);

    // Conflicting addresses in set 0 evict each other
    op(1, 0, 0, 0, 32'h10040, 0);
    chk("lit_conf1_stall", {31'd0, stall}, 32'd1);
    op(1, 0, 0, 0, 32'h10040, 0);
    op(1, 0, 0, 0, 32'h10000, 0);
    chk("lit_conf2_stall", {31'd0, stall}, 32'd1);
    op(1, 0, 0, 0, 32'h10000, 0);
    op(1, 0, 0, 0, 32'h10040, 0);
    chk("lit_conf3_stall", {31'd0, stall}, 32'd1);
    op(1, 0, 0, 0, 32'h10040, 0);

    // Misaligned word store invalidates both touched sets
    op(1, 0, 0, 0, 32'h10004, 0);
    op(1, 0, 0, 0, 32'h10004, 0);
    op(1, 0, 0, 0, 32'h10000, 0);
    op(1, 0, 0, 0, 32'h10000, 0);
    op(0, 1, 0, 0, 32'h10002, 32'h5566_7788);
    chk("lit_missw_mem_a", mem_a, 32'h10002);
    op(1, 0, 0, 0, 32'h10000, 0);
    chk("lit_inv0_stall", {31'd0, stall}, 32'd1);
    op(1, 0, 0, 0, 32'h10000, 0);
    chk("lit_refill_rd", rd, 32'h5566_7788);
    op(1, 0, 0, 0, 32'h10004, 0);
    chk("lit_inv1_stall", {31'd0, stall}, 32'd1);
    op(1, 0, 0, 0, 32'h10004, 0);

    // Store miss leaves the line alone; store beats a simultaneous read
    op(0, 1, 0, 0, 32'h10080, 32'h1111_2222);
    op(1, 0, 0, 0, 32'h10000, 0);
    chk("lit_stmiss_stall", {31'd0, stall}, 32'd0);
    chk("lit_stmiss_rd", rd, 32'h5566_7788);
    op(1, 1, 0, 0, 32'h10000, 32'hCAFE_F00D);
    chk("lit_rdst_stall", {31'd0, stall}, 32'd0);
    chk("lit_rdst_sw", {31'd0, mem_sw}, 32'd1);
    op(1, 0, 0, 0, 32'h10000, 0);
    chk("lit_rdst_rd", rd, 32'hCAFE_F00D);

    // Idle cycle
    op(0, 0, 0, 0, 32'h0000_0123, 0);
    chk("lit_idle_mem_a", mem_a, 32'h123);

    // Misaligned half store at offset 3 invalidates sets 1 and 2
    op(1, 0, 0, 0, 32'h10008, 0);
    op(1, 0, 0, 0, 32'h10008, 0);
    op(0, 0, 1, 0, 32'h10007, 32'h0000_BEEF);
    op(1, 0, 0, 0, 32'h10008, 0);
    chk("lit_shmis2_stall", {31'd0, stall}, 32'd1);
    op(1, 0, 0, 0, 32'h10008, 0);
    op(1, 0, 0, 0, 32'h10004, 0);
    chk("lit_shmis1_stall", {31'd0, stall}, 32'd1);
    op(1, 0, 0, 0, 32'h10004, 0);

    // Reset during a miss cycle abandons the fill
    op(1, 0, 0, 0, 32'h10048, 0);
    op(1, 0, 0, 0, 32'h10048, 0);
    @(posedge clk); #1;
    re = 1; sw = 0; sh = 0; sb = 0; a = 32'h10008; wd = 0;
    #2 chk("lit_pre_rst_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1 chk("lit_rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("lit_post_rst_stall", {31'd0, stall}, 32'd1);
    op(1, 0, 0, 0, 32'h10008, 0);
    op(1, 0, 0, 0, 32'h10000, 0);
    chk("lit_post_rst_miss0", {31'd0, stall}, 32'd1);
    op(1, 0, 0, 0, 32'h10000, 0);
    op(0, 0, 0, 0, 32'h0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
